// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller and its datapath.
// The slave modport is the controller side; the master modport is the datapath/driver side.
interface multicycle_control_if;
  logic [5:0]  op;
  logic        jump_reg;
  logic        zero;
  logic        iord;
  logic        memread;
  logic        memwrite;
  logic        irwrite;
  logic        pcwrite;
  logic        branch;
  logic [1:0]  pcsrc;
  logic        alusrca;
  logic [1:0]  alusrcb;
  logic [2:0]  aluop;
  logic        regdst;
  logic        memtoreg;
  logic        regwrite;
  logic [3:0]  state;
  logic        illegal;
  logic [15:0] instret;

  modport slave (
    input  op, jump_reg, zero,
    output iord, memread, memwrite, irwrite, pcwrite, branch, pcsrc,
           alusrca, alusrcb, aluop, regdst, memtoreg, regwrite,
           state, illegal, instret
  );

  modport master (
    output op, jump_reg, zero,
    input  iord, memread, memwrite, irwrite, pcwrite, branch, pcsrc,
           alusrca, alusrcb, aluop, regdst, memtoreg, regwrite,
           state, illegal, instret
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore controller for a multicycle MIPS-style datapath, with retired-instruction counter.
// Optional jr support (RTEXE -> JR) is enabled by defining MULTICYCLE_JR_EN.
module multicycle_control (
  input  logic                  clk,
  input  logic                  reset,
  multicycle_control_if.slave   bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    RTEXE  = 4'd6,
    RTWB   = 4'd7,
    BEQ    = 4'd8,
    IEXE   = 4'd9,
    IWB    = 4'd10,
    JUMP   = 4'd11,
    JR     = 4'd12
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RT   = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t      state_q, state_d;
  logic [15:0] instret_q;
  logic        illegal_q, illegal_d;
  logic        retire;
  logic [2:0]  imm_aluop_q;
  logic        unused_ok;

  function automatic logic [2:0] imm_aluop(input logic [5:0] op);
    case (op)
      OP_ANDI: imm_aluop = 3'b010;
      OP_ORI:  imm_aluop = 3'b011;
      default: imm_aluop = 3'b000;
    endcase
  endfunction

  // zero only qualifies branch outside this block; jump_reg is ignored without jr support
  assign unused_ok = bus.zero ^ bus.jump_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      instret_q <= 16'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      if (retire) instret_q <= instret_q + 16'd1;
    end
  end

  // Immediate ALU op is captured at decode so IEXE and IWB stay pure state decodes
  always_ff @(posedge clk) begin
    if (state_q == DECODE) imm_aluop_q <= imm_aluop(bus.op);
  end

  always_comb begin
    state_d   = FETCH;
    illegal_d = 1'b0;
    retire    = 1'b0;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (bus.op)
          OP_LW, OP_SW:              state_d = MEMADR;
          OP_RT:                     state_d = RTEXE;
          OP_BEQ:                    state_d = BEQ;
          OP_ADDI, OP_ANDI, OP_ORI:  state_d = IEXE;
          OP_J:                      state_d = JUMP;
          default: begin
            state_d   = FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      MEMADR: state_d = (bus.op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  state_d = MEMWB;
`ifdef MULTICYCLE_JR_EN
      RTEXE:  state_d = bus.jump_reg ? JR : RTWB;
      JR:     retire  = 1'b1;
`else
      RTEXE:  state_d = RTWB;
`endif
      IEXE:   state_d = IWB;
      MEMWB, MEMWR, RTWB, BEQ, IWB, JUMP: retire = 1'b1;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    bus.iord     = 1'b0;
    bus.memread  = 1'b0;
    bus.memwrite = 1'b0;
    bus.irwrite  = 1'b0;
    bus.pcwrite  = 1'b0;
    bus.branch   = 1'b0;
    bus.pcsrc    = 2'b00;
    bus.alusrca  = 1'b0;
    bus.alusrcb  = 2'b00;
    bus.aluop    = 3'b000;
    bus.regdst   = 1'b0;
    bus.memtoreg = 1'b0;
    bus.regwrite = 1'b0;
    case (state_q)
      FETCH: begin
        bus.memread = 1'b1;
        bus.irwrite = 1'b1;
        bus.pcwrite = 1'b1;
        bus.alusrcb = 2'b01;
      end
      DECODE: bus.alusrcb = 2'b11;
      MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
      end
      MEMRD: begin
        bus.memread = 1'b1;
        bus.iord    = 1'b1;
      end
      MEMWB: begin
        bus.regwrite = 1'b1;
        bus.memtoreg = 1'b1;
      end
      MEMWR: begin
        bus.memwrite = 1'b1;
        bus.iord     = 1'b1;
      end
      RTEXE: begin
        bus.alusrca = 1'b1;
        bus.aluop   = 3'b100;
      end
      RTWB: begin
        bus.regwrite = 1'b1;
        bus.regdst   = 1'b1;
      end
      BEQ: begin
        bus.alusrca = 1'b1;
        bus.aluop   = 3'b001;
        bus.branch  = 1'b1;
        bus.pcsrc   = 2'b01;
      end
      IEXE: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        bus.aluop   = imm_aluop_q;
      end
      IWB: begin
        bus.regwrite = 1'b1;
        bus.aluop    = imm_aluop_q;
      end
      JUMP: begin
        bus.pcwrite = 1'b1;
        bus.pcsrc   = 2'b10;
      end
`ifdef MULTICYCLE_JR_EN
      JR: begin
        bus.pcwrite = 1'b1;
        bus.pcsrc   = 2'b11;
      end
`endif
      default: ;
    endcase
  end

  assign bus.state   = state_q;
  assign bus.illegal = illegal_q;
  assign bus.instret = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: expected state sequences are queued per instruction
// and each cycle's state and control word are checked against a table built from the state list.
module tb_multicycle_control;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [15:0] exp_instret = 16'd0;
  logic [3:0]  exp_q [$];

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // {iord, memread, memwrite, irwrite, pcwrite, branch, pcsrc, alusrca, alusrcb, aluop, regdst, memtoreg, regwrite}
  logic [16:0] act_ctrl;
  assign act_ctrl = {bus.iord, bus.memread, bus.memwrite, bus.irwrite, bus.pcwrite, bus.branch,
                     bus.pcsrc, bus.alusrca, bus.alusrcb, bus.aluop,
                     bus.regdst, bus.memtoreg, bus.regwrite};

  function automatic logic [2:0] imm_op(input logic [5:0] o);
    if (o == 6'b001100) return 3'b010;
    if (o == 6'b001101) return 3'b011;
    return 3'b000;
  endfunction

  function automatic logic [16:0] exp_ctrl(input logic [3:0] s, input logic [5:0] o);
    logic iord, mrd, mwr, irw, pcw, br, asa, rdst, m2r, rw;
    logic [1:0] psrc, asb;
    logic [2:0] aop;
    {iord, mrd, mwr, irw, pcw, br, asa, rdst, m2r, rw} = '0;
    psrc = 2'b00; asb = 2'b00; aop = 3'b000;
    case (s)
      4'd0:  begin mrd = 1; irw = 1; pcw = 1; asb = 2'b01; end
      4'd1:  asb = 2'b11;
      4'd2:  begin asa = 1; asb = 2'b10; end
      4'd3:  begin mrd = 1; iord = 1; end
      4'd4:  begin rw = 1; m2r = 1; end
      4'd5:  begin mwr = 1; iord = 1; end
      4'd6:  begin asa = 1; aop = 3'b100; end
      4'd7:  begin rw = 1; rdst = 1; end
      4'd8:  begin asa = 1; aop = 3'b001; br = 1; psrc = 2'b01; end
      4'd9:  begin asa = 1; asb = 2'b10; aop = imm_op(o); end
      4'd10: begin rw = 1; aop = imm_op(o); end
      4'd11: begin pcw = 1; psrc = 2'b10; end
`ifdef MULTICYCLE_JR_EN
      4'd12: begin pcw = 1; psrc = 2'b11; end
`endif
      default: ;
    endcase
    return {iord, mrd, mwr, irw, pcw, br, psrc, asa, asb, aop, rdst, m2r, rw};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // seq holds the state list as nibbles, first state in the lowest nibble
  task automatic run_instr(input string tag, input logic [5:0] o, input logic jr, input logic z,
                           input int n, input logic [31:0] seq, input logic bad);
    logic [3:0]  es;
    logic [16:0] ec;
    int          cyc;
    bus.op = o; bus.jump_reg = jr; bus.zero = z;
    for (int i = 0; i < n; i++) exp_q.push_back(seq[4*i +: 4]);
    if (!bad) exp_instret = exp_instret + 16'd1;
    cyc = 0;
    while (exp_q.size() > 0) begin
      es = exp_q.pop_front();
      ec = exp_ctrl(es, o);
      chk({tag, "_state"}, 32'(bus.state), 32'(es));
      chk({tag, "_ctrl"}, 32'(act_ctrl), 32'(ec));
      chk({tag, "_pcen"}, 32'(bus.pcwrite | (bus.branch & bus.zero)), 32'(ec[12] | (ec[11] & z)));
      if (cyc > 0) chk({tag, "_illegal_mid"}, 32'(bus.illegal), 32'd0);
      cyc++;
      @(posedge clk); @(negedge clk);
    end
    chk({tag, "_illegal"}, 32'(bus.illegal), 32'(bad));
    chk({tag, "_instret"}, 32'(bus.instret), 32'(exp_instret));
  endtask

  initial begin
    reset = 1'b1;
    bus.op = 6'd0; bus.jump_reg = 1'b0; bus.zero = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_instret", 32'(bus.instret), 32'd0);
    chk("rst_illegal", 32'(bus.illegal), 32'd0);
    chk("rst_ctrl", 32'(act_ctrl), 32'(exp_ctrl(4'd0, 6'd0)));
    reset = 1'b0;

    run_instr("lw",     6'b100011, 1'b0, 1'b0, 5, 32'h0004_3210, 1'b0);
    run_instr("sw",     6'b101011, 1'b0, 1'b0, 4, 32'h0000_5210, 1'b0);
    run_instr("beq_z1", 6'b000100, 1'b0, 1'b1, 3, 32'h0000_0810, 1'b0);
    run_instr("beq_z0", 6'b000100, 1'b0, 1'b0, 3, 32'h0000_0810, 1'b0);
    run_instr("ill",    6'b111111, 1'b0, 1'b0, 2, 32'h0000_0010, 1'b1);
    run_instr("ori",    6'b001101, 1'b0, 1'b0, 4, 32'h0000_A910, 1'b0);
    run_instr("andi",   6'b001100, 1'b0, 1'b0, 4, 32'h0000_A910, 1'b0);
    run_instr("addi",   6'b001000, 1'b0, 1'b0, 4, 32'h0000_A910, 1'b0);
    run_instr("rtype",  6'b000000, 1'b0, 1'b0, 4, 32'h0000_7610, 1'b0);
`ifdef MULTICYCLE_JR_EN
    run_instr("jr",     6'b000000, 1'b1, 1'b0, 4, 32'h0000_C610, 1'b0);
`else
    run_instr("jr",     6'b000000, 1'b1, 1'b0, 4, 32'h0000_7610, 1'b0);
`endif
    run_instr("j",      6'b000010, 1'b0, 1'b0, 3, 32'h0000_0B10, 1'b0);
    run_instr("ill2",   6'b010101, 1'b0, 1'b0, 2, 32'h0000_0010, 1'b1);

    // reset asserted while a load sits in MEMRD
    bus.op = 6'b100011; bus.jump_reg = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    chk("mrd_reach", 32'(bus.state), 32'd3);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("mrd_rst_state", 32'(bus.state), 32'd0);
    chk("mrd_rst_instret", 32'(bus.instret), 32'd0);
    chk("mrd_rst_illegal", 32'(bus.illegal), 32'd0);
    reset = 1'b0;
    exp_instret = 16'd0;
    run_instr("post_rst_lw", 6'b100011, 1'b0, 1'b0, 5, 32'h0004_3210, 1'b0);

    // counter wrap: preload to all ones while sitting in FETCH, then retire a jump
    dut.instret_q = 16'hFFFF;
    exp_instret   = 16'hFFFF;
    run_instr("wrap_j", 6'b000010, 1'b0, 1'b0, 3, 32'h0000_0B10, 1'b0);
    chk("wrap_zero", 32'(bus.instret), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
